// File: rtl/ps2_scan_decoder_if.sv
// ps2_scan_decoder_if: byte-in / key-event-out port bundle of the PS/2 scan decoder.
interface ps2_scan_decoder_if #(parameter int CNT_W = 4);
  logic             rx_done_tick;
  logic [7:0]       rx_data;
  logic             evt_valid;
  logic             evt_ready;
  logic [9:0]       evt_data;
  logic [CNT_W-1:0] evt_count;
  logic             overflow;
  logic             ovf_clr;
  logic [2:0]       mods;
  modport master (
    output rx_done_tick, rx_data, evt_ready, ovf_clr,
    input  evt_valid, evt_data, evt_count, overflow, mods
  );
  modport slave (
    input  rx_done_tick, rx_data, evt_ready, ovf_clr,
    output evt_valid, evt_data, evt_count, overflow, mods
  );
endinterface

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: Set-2 byte stream to {brk,ext,code} events in a FWFT FIFO.
// Define PS2_MOD_TRACK_EN to track alt/ctrl/shift state on the mods output.
module ps2_scan_decoder #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic reset,
  ps2_scan_decoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE = 2'b00, EXT = 2'b01, BRK = 2'b10, EXT_BRK = 2'b11} state_t;
  state_t state, state_nx;
  logic is_f0, is_e0, is_disc, push;
  logic [9:0] push_evt;
  logic [9:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  logic full, pop, wr;
  assign is_f0 = bus.rx_data == 8'hF0;
  assign is_e0 = bus.rx_data == 8'hE0;
  assign is_disc = bus.rx_data inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1};
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // state bits are {brk, ext}: F0 sets brk, E0 sets ext, anything else returns to IDLE
  always_comb begin
    state_nx = state;
    if (bus.rx_done_tick)
      state_nx = is_f0 ? state_t'({1'b1, state[0]}) : is_e0 ? state_t'({state[1], 1'b1}) : IDLE;
  end
  always_comb begin
    push = bus.rx_done_tick && !is_f0 && !is_e0 && !(state == IDLE && is_disc);
    push_evt = {state, bus.rx_data};
  end
  assign full = count == CNT_W'(DEPTH);
  assign pop = bus.evt_valid && bus.evt_ready;
  assign wr = push && (!full || pop);
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= push_evt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      bus.overflow <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CNT_W'(wr) - CNT_W'(pop);
      if (push && full && !pop) bus.overflow <= 1'b1;
      else if (bus.ovf_clr) bus.overflow <= 1'b0;
    end
  assign bus.evt_valid = count != '0;
  assign bus.evt_count = count;
  assign bus.evt_data = bus.evt_valid ? mem[rptr] : 10'h000;
`ifdef PS2_MOD_TRACK_EN
  logic lshift, rshift, lctrl, rctrl, lalt, ralt;
  // updated on every decoded event, including ones dropped on overflow
  always_ff @(posedge clk or posedge reset)
    if (reset) {lshift, rshift, lctrl, rctrl, lalt, ralt} <= '0;
    else if (push) begin
      if (!push_evt[8] && bus.rx_data == 8'h12) lshift <= !push_evt[9];
      if (!push_evt[8] && bus.rx_data == 8'h59) rshift <= !push_evt[9];
      if (!push_evt[8] && bus.rx_data == 8'h14) lctrl <= !push_evt[9];
      if (push_evt[8] && bus.rx_data == 8'h14) rctrl <= !push_evt[9];
      if (!push_evt[8] && bus.rx_data == 8'h11) lalt <= !push_evt[9];
      if (push_evt[8] && bus.rx_data == 8'h11) ralt <= !push_evt[9];
    end
  assign bus.mods = {lalt | ralt, lctrl | rctrl, lshift | rshift};
`else
  assign bus.mods = 3'b000;
`endif
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder: directed scenarios against hand-computed events, counts and flags.
module tb_ps2_scan_decoder;
  localparam int DEPTH = 8;
`ifdef PS2_MOD_TRACK_EN
  localparam bit MT = 1'b1;
`else
  localparam bit MT = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  ps2_scan_decoder_if #(.CNT_W(4)) bus();
  ps2_scan_decoder #(.DEPTH(DEPTH), .CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_done_tick = 1'b1;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    bus.evt_ready = 1'b1;
    @(negedge clk);
    bus.evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({bus.evt_valid, bus.evt_data, bus.evt_count, bus.overflow, bus.mods} !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got v=%b d=%h c=%0d o=%b m=%b exp all 0",
               bus.evt_valid, bus.evt_data, bus.evt_count, bus.overflow, bus.mods);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_make();
    @(negedge clk);
    bus.rx_data = 8'h1C;
    bus.rx_done_tick = 1'b1;
    #1;
    vectors++;
    if (bus.evt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL make_latency got valid=%b exp 0 in tick cycle", bus.evt_valid);
    end
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
    vectors++;
    if (bus.evt_valid !== 1'b1 || bus.evt_data !== 10'h01C) begin
      miscompares++;
      $display("FAIL make_event got v=%b d=%h exp v=1 d=01c", bus.evt_valid, bus.evt_data);
    end
    pop_one();
    vectors++;
    if (bus.evt_valid !== 1'b0 || bus.evt_count !== 4'd0) begin
      miscompares++;
      $display("FAIL make_pop got v=%b c=%0d exp v=0 c=0", bus.evt_valid, bus.evt_count);
    end
  endtask

  task automatic test_ext_break();
    send(8'hE0);
    send(8'hF0);
    vectors++;
    if (bus.evt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ext_brk_prefix got valid=%b exp 0", bus.evt_valid);
    end
    send(8'h75);
    vectors++;
    if (bus.evt_data !== 10'h375 || bus.evt_count !== 4'd1) begin
      miscompares++;
      $display("FAIL ext_brk_event got d=%h c=%0d exp d=375 c=1", bus.evt_data, bus.evt_count);
    end
    pop_one();
  endtask

  task automatic test_discard();
    send(8'hAA);
    send(8'hFA);
    vectors++;
    if (bus.evt_count !== 4'd0) begin
      miscompares++;
      $display("FAIL discard_idle got c=%0d exp 0", bus.evt_count);
    end
    send(8'hF0);
    send(8'h1C);
    vectors++;
    if (bus.evt_data !== 10'h21C || bus.evt_count !== 4'd1) begin
      miscompares++;
      $display("FAIL discard_break got d=%h c=%0d exp d=21c c=1", bus.evt_data, bus.evt_count);
    end
    pop_one();
    send(8'hF0);
    send(8'hAA);
    vectors++;
    if (bus.evt_data !== 10'h2AA || bus.evt_count !== 4'd1) begin
      miscompares++;
      $display("FAIL prefixed_disc_code got d=%h c=%0d exp d=2aa c=1", bus.evt_data, bus.evt_count);
    end
    pop_one();
  endtask

  task automatic test_overflow();
    bus.evt_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      send(8'h1C);
      vectors++;
      if (bus.evt_count !== 4'(i + 1) || bus.overflow !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_%0d got c=%0d o=%b exp c=%0d o=0", i, bus.evt_count, bus.overflow, i + 1);
      end
    end
    send(8'h2B);
    vectors++;
    if (bus.evt_count !== 4'd8 || bus.overflow !== 1'b1 || bus.evt_data !== 10'h01C) begin
      miscompares++;
      $display("FAIL ovf_drop got c=%0d o=%b d=%h exp c=8 o=1 d=01c",
               bus.evt_count, bus.overflow, bus.evt_data);
    end
    @(negedge clk);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    vectors++;
    if (bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clr got o=%b exp 0", bus.overflow);
    end
    @(negedge clk);
    bus.ovf_clr = 1'b1;
    bus.rx_data = 8'h2B;
    bus.rx_done_tick = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    bus.rx_done_tick = 1'b0;
    vectors++;
    if (bus.overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set_wins got o=%b exp 1", bus.overflow);
    end
    @(negedge clk);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    @(negedge clk);
    bus.evt_ready = 1'b1;
    bus.rx_data = 8'h1D;
    bus.rx_done_tick = 1'b1;
    @(negedge clk);
    bus.evt_ready = 1'b0;
    bus.rx_done_tick = 1'b0;
    vectors++;
    if (bus.evt_count !== 4'd8 || bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL full_push_pop got c=%0d o=%b exp c=8 o=0", bus.evt_count, bus.overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (bus.evt_data !== (i == DEPTH - 1 ? 10'h01D : 10'h01C)) begin
        miscompares++;
        $display("FAIL drain_%0d got d=%h exp %h", i, bus.evt_data, i == DEPTH - 1 ? 10'h01D : 10'h01C);
      end
      pop_one();
    end
    @(negedge clk);
    bus.evt_ready = 1'b1;
    @(negedge clk);
    bus.evt_ready = 1'b0;
    vectors++;
    if (bus.evt_count !== 4'd0 || bus.evt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_empty got c=%0d v=%b exp c=0 v=0", bus.evt_count, bus.evt_valid);
    end
  endtask

  task automatic test_reset_mid();
    send(8'h1C);
    send(8'hE0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if ({bus.evt_valid, bus.evt_data, bus.evt_count, bus.overflow, bus.mods} !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs got v=%b d=%h c=%0d o=%b m=%b exp all 0",
               bus.evt_valid, bus.evt_data, bus.evt_count, bus.overflow, bus.mods);
    end
    @(negedge clk);
    reset = 1'b0;
    send(8'h1C);
    vectors++;
    if (bus.evt_data !== 10'h01C || bus.evt_count !== 4'd1) begin
      miscompares++;
      $display("FAIL reset_mid_event got d=%h c=%0d exp d=01c c=1", bus.evt_data, bus.evt_count);
    end
    pop_one();
  endtask

  task automatic test_mods();
    logic [7:0] seq [8] = '{8'h12, 8'h59, 8'hF0, 8'h12, 8'hF0, 8'h59, 8'hE0, 8'h14};
    logic [2:0] exp [8] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b010};
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(seq[i]);
      vectors++;
      if (bus.mods !== (MT ? exp[i] : 3'b000)) begin
        miscompares++;
        $display("FAIL mods_%0d got %b exp %b", i, bus.mods, MT ? exp[i] : 3'b000);
      end
    end
    bus.evt_ready = 1'b0;
  endtask

  initial begin
    bus.rx_done_tick = 1'b0;
    bus.rx_data = 8'h00;
    bus.evt_ready = 1'b0;
    bus.ovf_clr = 1'b0;
    test_reset();
    test_make();
    test_ext_break();
    test_discard();
    test_overflow();
    test_reset_mid();
    test_mods();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
